// File: rtl/dense_pkg.sv
// Shared constants for the dense/activation engine: activation encodings,
// FSM state type and Q-format / saturation helpers.
package dense_pkg;

    // act_mode encodings
    localparam logic [1:0] ACT_NONE  = 2'd0;
    localparam logic [1:0] ACT_RELU  = 2'd1;
    localparam logic [1:0] ACT_LEAKY = 2'd2;
    localparam logic [1:0] ACT_HSIG  = 2'd3;

    // FSM state
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_MAC  = 2'd1;
    localparam state_t S_FIN  = 2'd2;
    localparam state_t S_DONE = 2'd3;

    // 1.0 in Q format
    function automatic longint q_one(input int frac);
        return longint'(1) <<< frac;
    endfunction

    // 0.5 in Q format, also the round-half-up offset
    function automatic longint q_half(input int frac);
        return longint'(1) <<< (frac - 1);
    endfunction

    // signed saturation bounds for a w-bit value
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/act_unit.sv
// Combinational round / saturate / activate of a wide accumulator plus bias.
// Ports: acc (ACC_W, Q2FRAC), bias (DATA_W, QFRAC), mode (2), y (DATA_W, QFRAC).
module act_unit #(
    parameter int DATA_W = 16,
    parameter int FRAC   = 8,
    parameter int ACC_W  = 2 * DATA_W + 5
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [DATA_W-1:0] bias,
    input  logic        [1:0]        mode,
    output logic signed [DATA_W-1:0] y
);
    import dense_pkg::*;

    // two guard bits cover bias and rounding added on top of acc
    localparam int SW = ACC_W + 2;
    localparam int HW = DATA_W + 2;

    localparam logic signed [SW-1:0] RND  = SW'(q_half(FRAC));
    localparam logic signed [SW-1:0] SMAX = SW'(sat_max(DATA_W));
    localparam logic signed [SW-1:0] SMIN = SW'(sat_min(DATA_W));
    localparam logic signed [HW-1:0] HALF = HW'(q_half(FRAC));
    localparam logic signed [HW-1:0] ONE  = HW'(q_one(FRAC));

    logic signed [SW-1:0]     acc_x;
    logic signed [SW-1:0]     bias_x;
    logic signed [SW-1:0]     sum;
    logic signed [SW-1:0]     shf;
    logic signed [DATA_W-1:0] x;
    logic signed [HW-1:0]     x_w;
    logic signed [HW-1:0]     hs;

    always_comb begin
        acc_x  = SW'(acc);
        bias_x = SW'(bias) <<< FRAC;
        sum    = acc_x + bias_x + RND;
        shf    = sum >>> FRAC;

        if (shf > SMAX) begin
            x = SMAX[DATA_W-1:0];
        end else if (shf < SMIN) begin
            x = SMIN[DATA_W-1:0];
        end else begin
            x = shf[DATA_W-1:0];
        end

        // hard sigmoid evaluated in a wider signed domain before clamping
        x_w = HW'(x);
        hs  = (x_w >>> 2) + HALF;

        y = x;
        unique case (mode)
            ACT_NONE:  y = x;
            ACT_RELU:  y = x[DATA_W-1] ? '0 : x;
            ACT_LEAKY: y = x[DATA_W-1] ? (x >>> 3) : x;
            ACT_HSIG: begin
                if (hs < 0) begin
                    y = '0;
                end else if (hs > ONE) begin
                    y = ONE[DATA_W-1:0];
                end else begin
                    y = hs[DATA_W-1:0];
                end
            end
        endcase
    end

endmodule

// File: rtl/dense_act_engine.sv
// Dense layer (N_OUT neurons x N_IN inputs) with activation and argmax.
// Ports: clk/reset, start/act_mode, feature/weight/bias memory read ports,
// busy, per-neuron out_valid/out_idx/out_data, done_out/final_out/final_idx.
module dense_act_engine #(
    parameter int N_IN   = 16,
    parameter int N_OUT  = 10,
    parameter int DATA_W = 16,
    parameter int FRAC   = 8,
    parameter int ACC_W  = 2 * DATA_W + $clog2(N_IN) + 1,
    localparam int IW    = $clog2(N_IN),
    localparam int WW    = $clog2(N_IN * N_OUT),
    localparam int NW    = $clog2(N_OUT)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic        [1:0]        act_mode,
    output logic        [IW-1:0]     in_addr,
    input  logic signed [DATA_W-1:0] in_data,
    output logic        [WW-1:0]     w_addr,
    input  logic signed [DATA_W-1:0] w_data,
    output logic        [NW-1:0]     b_addr,
    input  logic signed [DATA_W-1:0] b_data,
    output logic                     busy,
    output logic                     out_valid,
    output logic        [NW-1:0]     out_idx,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     done_out,
    output logic signed [DATA_W-1:0] final_out,
    output logic        [NW-1:0]     final_idx
);
    import dense_pkg::*;

    localparam int KW = $clog2(N_IN + 1);

    localparam logic [KW-1:0] K_LAST = KW'(N_IN);
    localparam logic [KW-1:0] K_ADDR = KW'(N_IN - 1);
    localparam logic [NW-1:0] N_LAST = NW'(N_OUT - 1);

    localparam logic signed [DATA_W-1:0] VMIN =
        {1'b1, {(DATA_W-1){1'b0}}};

    state_t                     state;
    logic        [1:0]          mode_q;
    logic        [NW-1:0]       n;
    logic        [KW-1:0]       k;
    logic signed [ACC_W-1:0]    acc;
    logic signed [DATA_W-1:0]   bias_q;
    logic signed [DATA_W-1:0]   amax_v;
    logic        [NW-1:0]       amax_i;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [DATA_W-1:0]   act_y;

    assign prod = in_data * w_data;

    act_unit #(
        .DATA_W (DATA_W),
        .FRAC   (FRAC),
        .ACC_W  (ACC_W)
    ) u_act (
        .acc  (acc),
        .bias (bias_q),
        .mode (mode_q),
        .y    (act_y)
    );

    // MAC cycle k drives address k; the product for address k-1 lands
    // in cycle k, so a neuron spends N_IN+1 cycles in MAC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            mode_q    <= '0;
            n         <= '0;
            k         <= '0;
            acc       <= '0;
            bias_q    <= '0;
            amax_v    <= '0;
            amax_i    <= '0;
            in_addr   <= '0;
            w_addr    <= '0;
            b_addr    <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
            done_out  <= 1'b0;
            final_out <= '0;
            final_idx <= '0;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q   <= act_mode;
                        done_out <= 1'b0;
                        busy     <= 1'b1;
                        n        <= '0;
                        k        <= '0;
                        acc      <= '0;
                        amax_v   <= VMIN;
                        amax_i   <= '0;
                        in_addr  <= '0;
                        w_addr   <= '0;
                        b_addr   <= '0;
                        state    <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (k != '0) begin
                        acc <= acc + ACC_W'(prod);
                    end
                    if (k == KW'(1)) begin
                        bias_q <= b_data;
                    end
                    if (k < K_ADDR) begin
                        in_addr <= in_addr + 1'b1;
                        w_addr  <= w_addr + 1'b1;
                    end
                    if (k == K_LAST) begin
                        state <= S_FIN;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_FIN: begin
                    out_data  <= act_y;
                    out_idx   <= n;
                    out_valid <= 1'b1;
                    // strict compare keeps the lowest index on ties
                    if (act_y > amax_v) begin
                        amax_v <= act_y;
                        amax_i <= n;
                    end
                    if (n == N_LAST) begin
                        state <= S_DONE;
                    end else begin
                        n       <= n + 1'b1;
                        k       <= '0;
                        acc     <= '0;
                        in_addr <= '0;
                        w_addr  <= w_addr + 1'b1;
                        b_addr  <= n + 1'b1;
                        state   <= S_MAC;
                    end
                end
                S_DONE: begin
                    busy      <= 1'b0;
                    done_out  <= 1'b1;
                    final_out <= amax_v;
                    final_idx <= amax_i;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_act_engine.sv
// Self-checking bench for dense_act_engine (N_IN=4, N_OUT=3, Q8.8).
// Synchronous memories are modelled here; results come from an integer model.
module tb_dense_act_engine;

    localparam int N_IN   = 4;
    localparam int N_OUT  = 3;
    localparam int DATA_W = 16;
    localparam int FRAC   = 8;
    localparam int PER    = N_IN + 2;
    localparam int DONE_L = N_OUT * PER + 1;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     start = 1'b0;
    logic        [1:0]        act_mode = 2'd0;
    logic        [1:0]        in_addr;
    logic signed [DATA_W-1:0] in_data;
    logic        [3:0]        w_addr;
    logic signed [DATA_W-1:0] w_data;
    logic        [1:0]        b_addr;
    logic signed [DATA_W-1:0] b_data;
    logic                     busy;
    logic                     out_valid;
    logic        [1:0]        out_idx;
    logic signed [DATA_W-1:0] out_data;
    logic                     done_out;
    logic signed [DATA_W-1:0] final_out;
    logic        [1:0]        final_idx;

    dense_act_engine #(
        .N_IN   (N_IN),
        .N_OUT  (N_OUT),
        .DATA_W (DATA_W),
        .FRAC   (FRAC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .act_mode  (act_mode),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .busy      (busy),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .done_out  (done_out),
        .final_out (final_out),
        .final_idx (final_idx)
    );

    always #5 clk = ~clk;

    int feat [N_IN];
    int wmem [N_IN*N_OUT];
    int bmem [N_OUT];

    always @(posedge clk) begin
        in_data <= DATA_W'(feat[in_addr]);
        w_data  <= DATA_W'(wmem[w_addr]);
        b_data  <= DATA_W'(bmem[b_addr]);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    int ov_d [N_OUT];
    int ov_i [N_OUT];
    int ov_t [N_OUT];
    int nv;
    int done_t;
    int fin_v;
    int fin_i;
    bit tmo;
    bit acc_busy;
    bit acc_done;

    function automatic longint fdiv(input longint a, input longint b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    // dot product, Q rounding, saturation, then the activation formula
    function automatic int ref_neuron(input int n, input int mode);
        longint s;
        longint x;
        longint t;
        s = 0;
        for (int i = 0; i < N_IN; i++)
            s += longint'(feat[i]) * longint'(wmem[n*N_IN+i]);
        s += longint'(bmem[n]) * 256 + 128;
        x = fdiv(s, 256);
        if (x > 32767) x = 32767;
        if (x < -32768) x = -32768;
        case (mode)
            1: if (x < 0) x = 0;
            2: if (x < 0) x = fdiv(x, 8);
            3: begin
                t = fdiv(x, 4) + 128;
                x = (t < 0) ? 0 : ((t > 256) ? 256 : t);
            end
            default: ;
        endcase
        return int'(x);
    endfunction

    task automatic load_a();
        for (int i = 0; i < N_IN; i++) begin
            feat[i]          = 256;
            wmem[i]          = 128;
            wmem[N_IN+i]     = -256;
            wmem[2*N_IN+i]   = 64;
        end
        bmem[0] = 64;
        bmem[1] = 0;
        bmem[2] = 0;
    endtask

    // one run; act_mode is flipped right after acceptance, and with
    // glitch a start pulse is injected mid-run
    task automatic run_once(input logic [1:0] mode, input bit glitch);
        int t0;
        nv = 0;
        done_t = -1;
        tmo = 0;
        for (int j = 0; j < N_OUT; j++) begin
            ov_d[j] = -99999;
            ov_i[j] = -1;
            ov_t[j] = -1;
        end
        @(negedge clk);
        act_mode = mode;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        act_mode = ~mode;
        t0 = cyc;
        acc_busy = busy;
        acc_done = done_out;
        for (int c = 0; c < 60; c++) begin
            if (glitch) start = (c == 4 || c == 9);
            @(negedge clk);
            if (out_valid) begin
                if (nv < N_OUT) begin
                    ov_d[nv] = int'(out_data);
                    ov_i[nv] = int'(out_idx);
                    ov_t[nv] = cyc - t0;
                end
                nv++;
            end
            if (done_out) begin
                done_t = cyc - t0;
                fin_v = int'(final_out);
                fin_i = int'(final_idx);
                break;
            end
        end
        start = 1'b0;
        if (done_t < 0) tmo = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total_cnt++;
        if ({busy, out_valid, done_out} !== 3'b000)
            $display("FAIL reset_flags got=%b want=000",
                     {busy, out_valid, done_out});
        else pass_cnt++;
        total_cnt++;
        if ({in_addr, w_addr, b_addr} !== 8'h00)
            $display("FAIL reset_addr got=%h want=00",
                     {in_addr, w_addr, b_addr});
        else pass_cnt++;
        total_cnt++;
        if ({out_data, out_idx, final_out, final_idx} !== 36'h0)
            $display("FAIL reset_data got=%h want=0",
                     {out_data, out_idx, final_out, final_idx});
        else pass_cnt++;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({busy, out_valid, done_out} !== 3'b000)
            $display("FAIL idle_flags got=%b want=000",
                     {busy, out_valid, done_out});
        else pass_cnt++;
    endtask

    task automatic test_relu();
        int e [N_OUT] = '{576, 0, 256};
        load_a();
        run_once(2'd1, 1'b0);
        total_cnt++;
        if (tmo) $display("FAIL relu_timeout got=none want=done");
        else pass_cnt++;
        total_cnt++;
        if (acc_busy !== 1'b1 || acc_done !== 1'b0)
            $display("FAIL relu_accept got=busy%0d/done%0d want=1/0",
                     acc_busy, acc_done);
        else pass_cnt++;
        for (int j = 0; j < N_OUT; j++) begin
            total_cnt++;
            if (ov_d[j] !== e[j] || ov_i[j] !== j)
                $display("FAIL relu_out%0d got=%0d@%0d want=%0d@%0d",
                         j, ov_d[j], ov_i[j], e[j], j);
            else pass_cnt++;
            total_cnt++;
            if (ov_t[j] !== (j + 1) * PER)
                $display("FAIL relu_lat%0d got=%0d want=%0d",
                         j, ov_t[j], (j + 1) * PER);
            else pass_cnt++;
        end
        total_cnt++;
        if (done_t !== DONE_L)
            $display("FAIL relu_done_lat got=%0d want=%0d", done_t, DONE_L);
        else pass_cnt++;
        total_cnt++;
        if (fin_v !== 576 || fin_i !== 0)
            $display("FAIL relu_final got=%0d@%0d want=576@0", fin_v, fin_i);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0 || nv !== N_OUT)
            $display("FAIL relu_end got=busy%0d/nv%0d want=0/%0d",
                     busy, nv, N_OUT);
        else pass_cnt++;
    endtask

    task automatic test_leaky();
        load_a();
        run_once(2'd2, 1'b0);
        for (int j = 0; j < N_OUT; j++) begin
            total_cnt++;
            if (ov_d[j] !== ref_neuron(j, 2))
                $display("FAIL leaky_out%0d got=%0d want=%0d",
                         j, ov_d[j], ref_neuron(j, 2));
            else pass_cnt++;
        end
        total_cnt++;
        if (ov_d[1] !== -128)
            $display("FAIL leaky_neg got=%0d want=-128", ov_d[1]);
        else pass_cnt++;
        total_cnt++;
        if (fin_v !== 576 || fin_i !== 0 || done_t !== DONE_L)
            $display("FAIL leaky_final got=%0d@%0d t%0d want=576@0 t%0d",
                     fin_v, fin_i, done_t, DONE_L);
        else pass_cnt++;
    endtask

    task automatic test_sat();
        for (int i = 0; i < N_IN; i++) feat[i] = 32767;
        for (int i = 0; i < N_IN*N_OUT; i++) wmem[i] = 32767;
        for (int j = 0; j < N_OUT; j++) bmem[j] = 32767;
        run_once(2'd0, 1'b0);
        for (int j = 0; j < N_OUT; j++) begin
            total_cnt++;
            if (ov_d[j] !== 32767)
                $display("FAIL sat_out%0d got=%0d want=32767", j, ov_d[j]);
            else pass_cnt++;
        end
        total_cnt++;
        if (fin_v !== 32767 || fin_i !== 0)
            $display("FAIL sat_tie got=%0d@%0d want=32767@0", fin_v, fin_i);
        else pass_cnt++;
    endtask

    task automatic test_hsig();
        int e [N_OUT] = '{256, 0, 192};
        load_a();
        run_once(2'd3, 1'b0);
        for (int j = 0; j < N_OUT; j++) begin
            total_cnt++;
            if (ov_d[j] !== e[j])
                $display("FAIL hsig_out%0d got=%0d want=%0d",
                         j, ov_d[j], e[j]);
            else pass_cnt++;
        end
        total_cnt++;
        if (fin_v !== 256 || fin_i !== 0)
            $display("FAIL hsig_final got=%0d@%0d want=256@0", fin_v, fin_i);
        else pass_cnt++;
    endtask

    task automatic test_busy_start();
        int e [N_OUT] = '{576, 0, 256};
        load_a();
        run_once(2'd1, 1'b1);
        total_cnt++;
        if (done_t !== DONE_L || nv !== N_OUT)
            $display("FAIL busy_start got=t%0d/nv%0d want=t%0d/nv%0d",
                     done_t, nv, DONE_L, N_OUT);
        else pass_cnt++;
        for (int j = 0; j < N_OUT; j++) begin
            total_cnt++;
            if (ov_d[j] !== e[j])
                $display("FAIL busy_out%0d got=%0d want=%0d",
                         j, ov_d[j], e[j]);
            else pass_cnt++;
        end
        repeat (5) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || done_out !== 1'b1)
            $display("FAIL busy_idle got=busy%0d/done%0d want=0/1",
                     busy, done_out);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int ev;
        int e [N_OUT] = '{576, 0, 256};
        load_a();
        @(negedge clk);
        act_mode = 2'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (PER + 2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total_cnt++;
        if ({busy, out_valid, done_out, out_data, final_out,
             in_addr, w_addr, b_addr} !== 43'h0)
            $display("FAIL rst_mid_clear got=%0d/%0d/%0d/%0d a%0d/%0d/%0d",
                     busy, done_out, out_data, final_out,
                     in_addr, w_addr, b_addr);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        ev = 0;
        for (int c = 0; c < 3 * DONE_L; c++) begin
            @(negedge clk);
            if (out_valid || done_out || busy) ev++;
        end
        total_cnt++;
        if (ev !== 0)
            $display("FAIL rst_mid_quiet got=%0d want=0", ev);
        else pass_cnt++;
        run_once(2'd1, 1'b0);
        total_cnt++;
        if (done_t !== DONE_L || fin_v !== 576 || fin_i !== 0)
            $display("FAIL rst_rerun got=t%0d %0d@%0d want=t%0d 576@0",
                     done_t, fin_v, fin_i, DONE_L);
        else pass_cnt++;
        for (int j = 0; j < N_OUT; j++) begin
            total_cnt++;
            if (ov_d[j] !== e[j])
                $display("FAIL rst_rerun_out%0d got=%0d want=%0d",
                         j, ov_d[j], e[j]);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        int d1;
        int d2;
        int v2;
        load_a();
        @(negedge clk);
        act_mode = 2'd1;
        start = 1'b1;
        @(negedge clk);
        t0 = cyc;
        d1 = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done_out) begin
                d1 = cyc - t0;
                break;
            end
        end
        total_cnt++;
        if (d1 !== DONE_L)
            $display("FAIL b2b_first got=%0d want=%0d", d1, DONE_L);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done_out !== 1'b0 || busy !== 1'b1)
            $display("FAIL b2b_accept got=done%0d/busy%0d want=0/1",
                     done_out, busy);
        else pass_cnt++;
        start = 1'b0;
        t0 = cyc;
        d2 = -1;
        v2 = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) v2++;
            if (done_out) begin
                d2 = cyc - t0;
                break;
            end
        end
        total_cnt++;
        if (d2 !== DONE_L || v2 !== N_OUT || final_out !== 576)
            $display("FAIL b2b_second got=t%0d/nv%0d/%0d want=t%0d/nv%0d/576",
                     d2, v2, final_out, DONE_L, N_OUT);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int r;
        int best;
        int bi;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < N_IN; i++)
                feat[i] = (it == 7) ? int'($urandom_range(0, 65535)) - 32768
                                    : int'($urandom_range(0, 2047)) - 1024;
            for (int i = 0; i < N_IN*N_OUT; i++)
                wmem[i] = (it == 7) ? int'($urandom_range(0, 65535)) - 32768
                                    : int'($urandom_range(0, 1023)) - 512;
            for (int j = 0; j < N_OUT; j++)
                bmem[j] = int'($urandom_range(0, 4095)) - 2048;
            run_once(2'(it), 1'b0);
            best = -40000;
            bi = 0;
            for (int j = 0; j < N_OUT; j++) begin
                r = ref_neuron(j, it % 4);
                if (r > best) begin
                    best = r;
                    bi = j;
                end
                total_cnt++;
                if (ov_d[j] !== r || ov_i[j] !== j)
                    $display("FAIL rnd%0d_out%0d got=%0d@%0d want=%0d@%0d",
                             it, j, ov_d[j], ov_i[j], r, j);
                else pass_cnt++;
            end
            total_cnt++;
            if (tmo || fin_v !== best || fin_i !== bi)
                $display("FAIL rnd%0d_final got=%0d@%0d want=%0d@%0d",
                         it, fin_v, fin_i, best, bi);
            else pass_cnt++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N_IN; i++) feat[i] = 0;
        for (int i = 0; i < N_IN*N_OUT; i++) wmem[i] = 0;
        for (int j = 0; j < N_OUT; j++) bmem[j] = 0;
        test_reset();
        test_relu();
        test_leaky();
        test_sat();
        test_hsig();
        test_busy_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dense_act_engine.md
Name: dense_act_engine

Overview:
- Parametrised fully-connected (dense) layer with a selectable post-dense activation and an argmax reduction, all in Qm.FRAC fixed point.
- Generalises the single-output dense-plus-activation tail of the accelerator to N_OUT neurons, N_IN inputs, configurable width, a runtime activation mode, per-neuron output streaming and class-index selection.
- Sits after the flatten/feature buffer. It reads features, weights and biases from external synchronous memories.

Parameters:
- N_IN, 16: inputs per neuron (>=2).
- N_OUT, 10: output neurons (>=2).
- DATA_W, 16: signed data, weight and bias width.
- FRAC, 8: fractional bits (Q8.8 at default).
- ACC_W, 2*DATA_W+$clog2(N_IN)+1: accumulator width.

Ports:
- clk in 1: rising-edge clock.
- reset in 1: asynchronous, active-high reset.
- start in 1: run request, sampled in IDLE only.
- act_mode in 2: activation select (0 none, 1 ReLU, 2 leaky ReLU, 3 hard sigmoid); latched at start.
- in_addr out $clog2(N_IN): feature read address.
- in_data in DATA_W: feature data, valid 1 cycle after in_addr.
- w_addr out $clog2(N_IN*N_OUT): weight address, n*N_IN+i.
- w_data in DATA_W: weight data, 1-cycle read latency.
- b_addr out $clog2(N_OUT): bias address.
- b_data in DATA_W: bias data, 1-cycle latency, in Q format.
- busy out 1: high from start acceptance until done.
- out_valid out 1: 1-cycle pulse per finished neuron.
- out_idx out $clog2(N_OUT): neuron index for out_valid.
- out_data out DATA_W: activated neuron value.
- done_out out 1: level; high after the last neuron, cleared by the next accepted start.
- final_out out DATA_W: maximum activated value, held with done_out.
- final_idx out $clog2(N_OUT): index of that maximum.

Behaviour:
- Reset (async):
  - state=IDLE.
  - All outputs 0, including addresses, busy, out_valid, done_out, final_out and final_idx.
  - Accumulator, neuron counter and argmax registers cleared.
  - Reset mid-run abandons the run; no out_valid or done_out follows.
- FSM states: IDLE -> MAC -> FIN -> (MAC for the next neuron | DONE); DONE -> IDLE.
- IDLE:
  - start=1 at an edge: latch act_mode, clear done_out, set busy.
  - Set n=0, i=0; load the argmax value with the most negative value and the argmax index with 0.
- MAC (N_IN+1 cycles per neuron):
  - Cycle k (k<N_IN) drives in_addr=k and w_addr=n*N_IN+k.
  - Cycle k+1 adds the sign-extended in_data*w_data into the accumulator.
  - b_addr=n is driven on the first MAC cycle and b_data is captured.
  - Accumulator is cleared at neuron start. It never overflows by construction of ACC_W.
- FIN (1 cycle):
  - s = acc + (bias <<< FRAC) + (1 <<< (FRAC-1)), then arithmetic shift right by FRAC (round half up).
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Apply activation:
    - none: x.
    - ReLU: max(x,0).
    - leaky: x>=0 ? x : x>>>3.
    - hard sigmoid: clamp((x>>>2) + 0.5, 0, 1.0), where 0.5 = 1<<(FRAC-1) and 1.0 = 1<<FRAC.
  - Register out_data/out_idx with out_valid=1 on the next cycle.
  - Argmax updates only on strictly greater, so ties keep the lowest index.
  - If n<N_OUT-1: n++, return to MAC; otherwise go to DONE.
- DONE (1 cycle): busy=0, done_out=1, final_out and final_idx updated together, return to IDLE.
- Latency:
  - out_valid for neuron n is asserted (n+1)*(N_IN+2) cycles after the start-sampling edge.
  - done_out rises N_OUT*(N_IN+2)+1 cycles after that edge.
- start while busy is ignored.
- start in the same cycle done_out rises is ignored; start is accepted from the following cycle.
- act_mode changes mid-run have no effect.
- Addresses hold their last value when not in MAC.

Decomposition:
- Shared package dense_pkg holds:
  - act_mode encodings ACT_NONE/ACT_RELU/ACT_LEAKY/ACT_HSIG.
  - FSM state typedef.
  - Q-format helper constants (ONE=1<<FRAC, HALF).
  - Saturation bounds.
- One natural sub-module, act_unit: combinational round/saturate plus activation. Takes the accumulator, bias and mode; returns DATA_W. It is reused by the conv-stage activation.

Test Plan:
Common configuration: N_IN=4, N_OUT=3, DATA_W=16, FRAC=8, all in_data=256 (1.0).
- ReLU run:
  - Stimulus: w0=128 with b0=64; w1=-256 with b1=0; w2=64 with b2=0.
  - Expected out_data: 576, 0, 256.
  - Expected final: final_out=576, final_idx=0; done_out exactly 19 cycles after start.
- Leaky mode, same memories: neuron1 outputs -128; final_out=576.
- Saturation: all weights and in_data=32767, bias 32767 -> every neuron outputs 32767. Mode none; final_idx=0 (tie rule).
- Hard sigmoid: neuron0 -> 256 (clamped), neuron1 -> 0, neuron2 -> 192 (1.0/4+0.5).
- Robustness and handshake:
  - Start pulse while busy is ignored.
  - Reset asserted during neuron 1 -> all outputs 0 immediately, no done_out.
  - Subsequent start completes with identical results.
  - Back-to-back: start held high -> the second run begins the cycle after DONE; done_out drops on acceptance.
